alu_cmd_driver: RTL

Initiator-side front end for the registered 8-bit ALU. Accepts operation commands over a valid/ready interface and buffers them in a small FIFO. Issues one operation at a time to the ALU's A/B/selection inputs, captures result/carry_out after the ALU's one-cycle register latency, and returns a tagged response over a valid/ready interface. Sits between the command source (bench sequencer or control logic) and the ALU instance.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_cmd_fifo.sv | 62 ++++++
 rtl/alu_cmd_driver.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit registered ALU, its command driver and benches.
package alu_pkg;

  localparam int DATA_W    = 8;
  localparam int OP_W      = 4;
  localparam int DEF_TAG_W = 4;

  typedef enum logic [OP_W-1:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    DIV  = 4'd5,
    SHL  = 4'd6,
    SHR  = 4'd7,
    NAND = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
    logic [OP_W-1:0]      op;
    logic [DEF_TAG_W-1:0] tag;
  } alu_cmd_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return op <= NAND;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with show-ahead head entry; push/pop are ignored when full/empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = alu_cmd_t
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  entry_t wr_data,
  input  logic   pop,
  output entry_t rd_data,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator front end for the registered ALU: buffers commands, issues one at a time,
// captures the ALU output one cycle after issue and returns a tagged response.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag;
  } cmd_t;

  state_e            state_q, state_d;
  cmd_t              cmd_in, head;
  logic              fifo_full, fifo_empty, pop;

  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_sel_q, alu_sel_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic              rsp_err_q, rsp_err_d;

  assign cmd_in = '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};
  assign pop    = (state_q == S_IDLE) && !fifo_empty;

  alu_cmd_fifo #(
    .DEPTH   (CMD_DEPTH),
    .entry_t (cmd_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cmd_valid),
    .wr_data (cmd_in),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!fifo_empty) state_d = is_legal_op(head.op) ? S_ISSUE : S_RESP;
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    if (rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = !fifo_full;
    rsp_valid = (state_q == S_RESP);
    busy      = (state_q != S_IDLE) || !fifo_empty;
  end

  // Illegal ops bypass the ALU entirely and leave its inputs untouched.
  always_comb begin
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    tag_d        = tag_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_err_d    = rsp_err_q;
    if (pop) begin
      if (is_legal_op(head.op)) begin
        alu_a_d   = head.a;
        alu_b_d   = head.b;
        alu_sel_d = head.op;
        tag_d     = head.tag;
      end else begin
        rsp_result_d = '0;
        rsp_carry_d  = 1'b0;
        rsp_err_d    = 1'b1;
        rsp_tag_d    = head.tag;
      end
    end else if (state_q == S_CAPTURE) begin
      rsp_result_d = alu_result;
      rsp_carry_d  = alu_carry;
      rsp_tag_d    = tag_q;
      rsp_err_d    = (alu_sel_q == DIV) && (alu_b_q == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      tag_q        <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      tag_q        <= tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;

endmodule
